// File: rtl/ixc_sfifo_rx_assembler.sv
`default_nettype none
// ============================================================================
// ixc_sfifo_rx_assembler : packs header + 1..8 x 64-bit link words into one
// 512-bit beat held for the addressed ixc_sfifo_port until its fen pulse.
// Revision: 1.0
// ============================================================================
module ixc_sfifo_rx_assembler #(
    parameter logic [21:0] IDLE_TID  = 22'h3FFFFF,
    parameter int          MAX_WORDS = 8
) (
    input  logic                       fclk,
    input  logic                       fresetn,
    input  logic [63:0]                wdata,
    input  logic                       wvalid,
    input  logic                       wsop,
    input  logic                       weop,
    output logic                       wready,
    output logic [64*MAX_WORDS-1:0]    CiData,
    output logic [21:0]                CtId,
    input  logic                       fen,
    output logic [7:0]                 err_cnt,
    output logic                       busy
);

    localparam logic [3:0] MAX_LEN = 4'(MAX_WORDS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_DONE    = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [3:0]                idx;
    logic [3:0]                idx_nxt;
    logic [3:0]                len;
    logic [3:0]                len_nxt;
    logic [21:0]               tid;
    logic [21:0]               tid_nxt;
    logic [64*MAX_WORDS-1:0]   asm_buf;
    logic [64*MAX_WORDS-1:0]   buf_nxt;
    logic                      out_valid;
    logic [1:0]                err_inc;
    logic                      load;
    logic                      take_hdr;
    logic                      accept;
    logic [3:0]                hdr_len;
    logic [21:0]               hdr_tid;
    logic                      hdr_ok;
    logic [8:0]                err_sum;
    logic                      unused_hdr_bits;

    assign hdr_tid         = wdata[21:0];
    assign hdr_len         = wdata[25:22];
    assign unused_hdr_bits = ^wdata[63:26];
    assign hdr_ok          = (hdr_len != 4'd0) && (hdr_len <= MAX_LEN) && (hdr_tid != IDLE_TID);

    assign wready = (state != S_DONE);
    assign accept = wvalid && wready;
    assign busy   = (state != S_IDLE) || out_valid;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        len_nxt   = len;
        tid_nxt   = tid;
        buf_nxt   = asm_buf;
        err_inc   = 2'd0;
        load      = 1'b0;
        take_hdr  = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept && wsop) begin
                    take_hdr = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    if (wsop) begin
                        // A new header aborts the frame in progress and is
                        // then evaluated exactly as it would be from IDLE.
                        err_inc  = 2'd1;
                        take_hdr = 1'b1;
                    end else begin
                        for (int k = 0; k < MAX_WORDS; k++) begin
                            if (idx == 4'(k)) begin
                                buf_nxt[64*k +: 64] = wdata;
                            end
                        end
                        idx_nxt = idx + 4'd1;
                        if (idx == len - 4'd1) begin
                            if (weop) begin
                                state_nxt = S_DONE;
                            end else begin
                                err_inc   = 2'd1;
                                state_nxt = S_FLUSH;
                            end
                        end else if (weop) begin
                            err_inc   = 2'd1;
                            state_nxt = S_IDLE;
                        end
                    end
                end
            end
            S_DONE: begin
                if (!out_valid || fen) begin
                    load      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (accept && weop) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (take_hdr) begin
            if (hdr_ok) begin
                tid_nxt   = hdr_tid;
                len_nxt   = hdr_len;
                buf_nxt   = '0;
                idx_nxt   = 4'd0;
                state_nxt = S_PAYLOAD;
            end else begin
                err_inc   = err_inc + 2'd1;
                state_nxt = weop ? S_IDLE : S_FLUSH;
            end
        end
    end

    // Up to two errors can land in one cycle (aborted frame + bad header).
    assign err_sum = {1'b0, err_cnt} + {7'd0, err_inc};

    always_ff @(posedge fclk or negedge fresetn) begin
        if (!fresetn) begin
            state     <= S_IDLE;
            idx       <= 4'd0;
            len       <= 4'd0;
            tid       <= IDLE_TID;
            asm_buf   <= '0;
            out_valid <= 1'b0;
            CiData    <= '0;
            CtId      <= IDLE_TID;
            err_cnt   <= 8'd0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            len     <= len_nxt;
            tid     <= tid_nxt;
            asm_buf <= buf_nxt;
            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
            // A load in the same cycle as fen takes priority over the clear.
            if (load) begin
                CiData    <= asm_buf;
                CtId      <= tid;
                out_valid <= 1'b1;
            end else if (fen && out_valid) begin
                CiData    <= '0;
                CtId      <= IDLE_TID;
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ixc_sfifo_rx_assembler.sv
`default_nettype none
// ============================================================================
// tb_ixc_sfifo_rx_assembler : directed and randomized frame stimulus checked
// against a frame-level reference model. Revision: 1.0
// ============================================================================
module tb_ixc_sfifo_rx_assembler;

    localparam logic [21:0] IDLE = 22'h3FFFFF;

    logic         fclk = 1'b0;
    logic         fresetn = 1'b0;
    logic [63:0]  wdata = '0;
    logic         wvalid = 1'b0;
    logic         wsop = 1'b0;
    logic         weop = 1'b0;
    logic         wready;
    logic [511:0] CiData;
    logic [21:0]  CtId;
    logic         fen = 1'b0;
    logic [7:0]   err_cnt;
    logic         busy;

    int checks = 0;
    int passes = 0;
    int exp_err = 0;

    ixc_sfifo_rx_assembler #(.IDLE_TID(22'h3FFFFF), .MAX_WORDS(8)) dut (
        .fclk(fclk), .fresetn(fresetn), .wdata(wdata), .wvalid(wvalid),
        .wsop(wsop), .weop(weop), .wready(wready), .CiData(CiData),
        .CtId(CtId), .fen(fen), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 fclk = ~fclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic send_word(input logic [63:0] d, input logic sop, input logic eop);
        int n = 0;
        @(negedge fclk);
        wdata = d; wsop = sop; weop = eop; wvalid = 1'b1;
        while (wready !== 1'b1 && n < 50) begin
            @(negedge fclk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            $display("FAIL send_word_timeout: wready got=%b exp=1", wready);
        end
        @(posedge fclk);
        #1;
        wvalid = 1'b0; wsop = 1'b0; weop = 1'b0;
    endtask

    task automatic fen_pulse();
        @(negedge fclk);
        fen = 1'b1;
        @(posedge fclk);
        #1;
        fen = 1'b0;
    endtask

    // Header carries random ignored upper bits; eop_at = 0 marks the header,
    // eop_at = i marks payload word i. exp holds the beat a good frame makes.
    task automatic send_frame(input logic [21:0] t, input logic [3:0] l, input int nwords,
                              input int eop_at, output logic [511:0] exp);
        logic [63:0] h;
        logic [63:0] w;
        exp = '0;
        h = {$urandom, $urandom};
        h[25:0] = {l, t};
        send_word(h, 1'b1, eop_at == 0);
        for (int i = 1; i <= nwords; i++) begin
            w = {$urandom, $urandom};
            if (i <= 8) exp[64*(i-1) +: 64] = w;
            send_word(w, 1'b0, eop_at == i);
        end
    endtask

    task automatic wait_beat(output bit found);
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge fclk);
            if (CtId !== IDLE) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge fclk);
        checks++; if (CtId !== IDLE) $display("FAIL reset_ctid got=%h exp=%h", CtId, IDLE); else passes++;
        checks++; if (CiData !== '0) $display("FAIL reset_cidata got=%h exp=0", CiData); else passes++;
        checks++; if (err_cnt !== 8'd0) $display("FAIL reset_err got=%0d exp=0", err_cnt); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
        checks++; if (wready !== 1'b1) $display("FAIL reset_wready got=%b exp=1", wready); else passes++;
        @(negedge fclk);
        fresetn = 1'b1;
    endtask

    task automatic test_single_frame();
        send_word({38'd0, 4'd2, 22'h00012}, 1'b1, 1'b0);
        send_word(64'hA, 1'b0, 1'b0);
        send_word(64'hB, 1'b0, 1'b1);
        @(negedge fclk);
        checks++; if (CtId !== IDLE) $display("FAIL single_early got=%h exp=%h", CtId, IDLE); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy); else passes++;
        @(negedge fclk);
        checks++; if (CtId !== 22'h00012) $display("FAIL single_tid got=%h exp=00012", CtId); else passes++;
        checks++; if (CiData[127:0] !== {64'hB, 64'hA}) $display("FAIL single_low got=%h exp=%h", CiData[127:0], {64'hB, 64'hA}); else passes++;
        checks++; if (CiData[511:128] !== '0) $display("FAIL single_high got=%h exp=0", CiData[511:128]); else passes++;
        fen_pulse();
        @(negedge fclk);
        checks++; if (CtId !== IDLE) $display("FAIL single_clear_tid got=%h exp=%h", CtId, IDLE); else passes++;
        checks++; if (CiData !== '0) $display("FAIL single_clear_data got=%h exp=0", CiData); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL single_clear_busy got=%b exp=0", busy); else passes++;
    endtask

    task automatic test_backpressure();
        logic [511:0] ea, eb;
        send_frame(22'h0A0A0, 4'd8, 8, 8, ea);
        send_frame(22'h0B0B0, 4'd8, 8, 8, eb);
        repeat (3) @(negedge fclk);
        checks++; if (wready !== 1'b0) $display("FAIL bp_wready_low got=%b exp=0", wready); else passes++;
        checks++; if (CtId !== 22'h0A0A0) $display("FAIL bp_first_tid got=%h exp=0a0a0", CtId); else passes++;
        checks++; if (CiData !== ea) $display("FAIL bp_first_data got=%h exp=%h", CiData, ea); else passes++;
        fen = 1'b1;
        @(posedge fclk);
        #1;
        fen = 1'b0;
        @(negedge fclk);
        checks++; if (CtId !== 22'h0B0B0) $display("FAIL bp_second_tid got=%h exp=0b0b0", CtId); else passes++;
        checks++; if (CiData !== eb) $display("FAIL bp_second_data got=%h exp=%h", CiData, eb); else passes++;
        checks++; if (wready !== 1'b1) $display("FAIL bp_wready_high got=%b exp=1", wready); else passes++;
        fen_pulse();
        @(negedge fclk);
        checks++; if (CtId !== IDLE) $display("FAIL bp_clear got=%h exp=%h", CtId, IDLE); else passes++;
    endtask

    task automatic test_bad_header();
        logic [511:0] d, e;
        bit found;
        send_frame(22'h00055, 4'd0, 2, 2, d); exp_err = sat(exp_err + 1);
        send_frame(22'h00066, 4'd9, 2, 2, d); exp_err = sat(exp_err + 1);
        @(negedge fclk);
        checks++; if (err_cnt !== 8'(exp_err)) $display("FAIL badhdr_err got=%0d exp=%0d", err_cnt, exp_err); else passes++;
        checks++; if (CtId !== IDLE) $display("FAIL badhdr_nobeat got=%h exp=%h", CtId, IDLE); else passes++;
        send_frame(IDLE, 4'd2, 0, 0, d); exp_err = sat(exp_err + 1);
        @(negedge fclk);
        checks++; if (err_cnt !== 8'(exp_err)) $display("FAIL badhdr_idletid_err got=%0d exp=%0d", err_cnt, exp_err); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL badhdr_idletid_busy got=%b exp=0", busy); else passes++;
        send_frame(22'h00077, 4'd3, 3, 3, e);
        wait_beat(found);
        checks++; if (found !== 1'b1) $display("FAIL badhdr_good_timeout got=%b exp=1", found); else passes++;
        checks++; if (CtId !== 22'h00077) $display("FAIL badhdr_good_tid got=%h exp=00077", CtId); else passes++;
        checks++; if (CiData !== e) $display("FAIL badhdr_good_data got=%h exp=%h", CiData, e); else passes++;
        fen_pulse();
    endtask

    task automatic test_framing_errors();
        logic [511:0] d, e;
        bit found;
        send_frame(22'h00101, 4'd3, 2, 2, d); exp_err = sat(exp_err + 1);
        @(negedge fclk);
        checks++; if (err_cnt !== 8'(exp_err)) $display("FAIL early_eop_err got=%0d exp=%0d", err_cnt, exp_err); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL early_eop_busy got=%b exp=0", busy); else passes++;
        send_frame(22'h00102, 4'd2, 5, 5, d); exp_err = sat(exp_err + 1);
        @(negedge fclk);
        checks++; if (err_cnt !== 8'(exp_err)) $display("FAIL flush_err got=%0d exp=%0d", err_cnt, exp_err); else passes++;
        checks++; if (busy !== 1'b0 || CtId !== IDLE) $display("FAIL flush_idle got busy=%b tid=%h exp busy=0 tid=%h", busy, CtId, IDLE); else passes++;
        send_word({38'd0, 4'd3, 22'h00103}, 1'b1, 1'b0);
        send_word(64'hDEAD, 1'b0, 1'b0);
        send_frame(22'h00104, 4'd2, 2, 2, e); exp_err = sat(exp_err + 1);
        wait_beat(found);
        checks++; if (found !== 1'b1) $display("FAIL sop_in_payload_timeout got=%b exp=1", found); else passes++;
        checks++; if (CtId !== 22'h00104) $display("FAIL sop_in_payload_tid got=%h exp=00104", CtId); else passes++;
        checks++; if (CiData !== e) $display("FAIL sop_in_payload_data got=%h exp=%h", CiData, e); else passes++;
        checks++; if (err_cnt !== 8'(exp_err)) $display("FAIL sop_in_payload_err got=%0d exp=%0d", err_cnt, exp_err); else passes++;
        fen_pulse();
    endtask

    task automatic test_fen_load_collision();
        logic [511:0] ea, eb;
        bit found;
        send_frame(22'h00A01, 4'd1, 1, 1, ea);
        wait_beat(found);
        send_frame(22'h00B02, 4'd2, 2, 2, eb);
        @(negedge fclk);
        checks++; if (wready !== 1'b0) $display("FAIL coll_parked got=%b exp=0", wready); else passes++;
        fen = 1'b1;
        @(posedge fclk);
        #1;
        fen = 1'b0;
        @(negedge fclk);
        checks++; if (CtId !== 22'h00B02) $display("FAIL coll_tid got=%h exp=00b02", CtId); else passes++;
        checks++; if (CiData !== eb) $display("FAIL coll_data got=%h exp=%h", CiData, eb); else passes++;
        @(negedge fclk);
        checks++; if (CtId !== 22'h00B02) $display("FAIL coll_stable got=%h exp=00b02", CtId); else passes++;
        fen_pulse();
        fen_pulse();
        @(negedge fclk);
        checks++; if (CtId !== IDLE || busy !== 1'b0) $display("FAIL fen_empty got tid=%h busy=%b exp tid=%h busy=0", CtId, busy, IDLE); else passes++;
    endtask

    task automatic test_random();
        logic [511:0] e;
        logic [21:0]  t;
        logic [3:0]   l;
        int           kind, n;
        bit           found;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 3);
            t = 22'($urandom_range(0, 32'h3FFFFE));
            case (kind)
                0: begin
                    l = 4'($urandom_range(1, 8));
                    send_frame(t, l, int'(l), int'(l), e);
                    wait_beat(found);
                    checks++; if (found !== 1'b1 || CtId !== t) $display("FAIL rand_tid it=%0d got=%h exp=%h", it, CtId, t); else passes++;
                    checks++; if (CiData !== e) $display("FAIL rand_data it=%0d got=%h exp=%h", it, CiData, e); else passes++;
                    fen_pulse();
                end
                1: begin
                    case ($urandom_range(0, 2))
                        0: l = 4'd0;
                        1: l = 4'($urandom_range(9, 15));
                        default: begin l = 4'($urandom_range(1, 8)); t = IDLE; end
                    endcase
                    if ($urandom_range(0, 1) == 0) send_frame(t, l, 0, 0, e);
                    else begin n = $urandom_range(1, 4); send_frame(t, l, n, n, e); end
                    exp_err = sat(exp_err + 1);
                end
                2: begin
                    l = 4'($urandom_range(2, 8));
                    n = $urandom_range(1, int'(l) - 1);
                    send_frame(t, l, n, n, e);
                    exp_err = sat(exp_err + 1);
                end
                default: begin
                    l = 4'($urandom_range(1, 8));
                    n = int'(l) + $urandom_range(1, 3);
                    send_frame(t, l, n, n, e);
                    exp_err = sat(exp_err + 1);
                end
            endcase
            @(negedge fclk);
            checks++; if (err_cnt !== 8'(exp_err)) $display("FAIL rand_err it=%0d kind=%0d got=%0d exp=%0d", it, kind, err_cnt, exp_err); else passes++;
            checks++; if (CtId !== IDLE) $display("FAIL rand_idle it=%0d kind=%0d got=%h exp=%h", it, kind, CtId, IDLE); else passes++;
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            send_word({38'd0, 4'd0, 22'h00001}, 1'b1, 1'b1);
        end
        exp_err = sat(exp_err + 300);
        @(negedge fclk);
        checks++; if (err_cnt !== 8'(exp_err)) $display("FAIL sat_err got=%0d exp=%0d", err_cnt, exp_err); else passes++;
        send_word({38'd0, 4'd12, 22'h00001}, 1'b1, 1'b1);
        exp_err = sat(exp_err + 1);
        @(negedge fclk);
        checks++; if (err_cnt !== 8'(exp_err)) $display("FAIL sat_hold got=%0d exp=%0d", err_cnt, exp_err); else passes++;
    endtask

    task automatic test_reset_mid_frame();
        logic [511:0] e;
        bit found;
        send_frame(22'h00300, 4'd1, 1, 1, e);
        wait_beat(found);
        send_word({38'd0, 4'd6, 22'h00200}, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, 1'b0, 1'b0);
        @(negedge fclk);
        fresetn = 1'b0;
        exp_err = 0;
        #1;
        checks++; if (CtId !== IDLE) $display("FAIL rst_mid_tid got=%h exp=%h", CtId, IDLE); else passes++;
        checks++; if (CiData !== '0) $display("FAIL rst_mid_data got=%h exp=0", CiData); else passes++;
        checks++; if (err_cnt !== 8'd0) $display("FAIL rst_mid_err got=%0d exp=0", err_cnt); else passes++;
        checks++; if (busy !== 1'b0 || wready !== 1'b1) $display("FAIL rst_mid_ctrl got busy=%b wready=%b exp busy=0 wready=1", busy, wready); else passes++;
        @(negedge fclk);
        fresetn = 1'b1;
        send_frame(22'h00201, 4'd4, 4, 4, e);
        wait_beat(found);
        checks++; if (found !== 1'b1 || CtId !== 22'h00201) $display("FAIL rst_mid_next_tid got=%h exp=00201", CtId); else passes++;
        checks++; if (CiData !== e) $display("FAIL rst_mid_next_data got=%h exp=%h", CiData, e); else passes++;
        checks++; if (err_cnt !== 8'(exp_err)) $display("FAIL rst_mid_next_err got=%0d exp=%0d", err_cnt, exp_err); else passes++;
        fen_pulse();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_bad_header();
        test_framing_errors();
        test_fen_load_collision();
        test_random();
        test_saturation();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ixc_sfifo_rx_assembler.md
# ixc_sfifo_rx_assembler

Inbound assembler feeding the `ixc_sfifo_port` instances of the transaction-FIFO channel. It takes a 64-bit word stream from the host link, framed as a header word plus 1–8 payload words. It assembles each frame into one 512-bit beat and presents it on `CiData`/`CtId`. The beat is held until the addressed port acknowledges it with its `fen` pulse. Two stages: an assembly buffer and an output register, so the next frame assembles while the current beat waits.

## Interface
Parameters:
- `IDLE_TID`, 22'h3FFFFF: value driven on `CtId` when no beat is held. Never matches a port `tid`.
- `MAX_WORDS`, 8: maximum payload words per frame (512/64).

Ports:
- `fclk` input 1: clock, all logic rising-edge.
- `fresetn` input 1: asynchronous active-low reset.
- `wdata` input 64: link word.
- `wvalid` input 1: `wdata` valid.
- `wsop` input 1: word is a header (start of frame).
- `weop` input 1: word is last of frame.
- `wready` output 1: word accepted when `wvalid & wready`.
- `CiData` output 512: held beat. Payload word k sits at [64k+63:64k]; unfilled words are 0.
- `CtId` output 22: target transaction id of held beat; `IDLE_TID` when empty.
- `fen` input 1: acknowledge pulse from the addressed port; frees the output register.
- `err_cnt` output 8: saturating count of dropped frames.
- `busy` output 1: assembly state ≠ IDLE or output register occupied.

## Operation
- Header word fields: tid = `wdata[21:0]`, len = `wdata[25:22]` (payload word count), `wdata[63:26]` ignored.
- Assembly FSM states:
  - IDLE: waits for an accepted word with `wsop`.
  - PAYLOAD: collects len words; word index counter 0..len-1.
  - DONE: frame complete, waiting for the output register.
  - FLUSH: discards words until an accepted `weop`.
- IDLE transitions:
  - Accepted `wsop` word, len in 1..8, tid ≠ `IDLE_TID`: latch tid and len, clear buffer to 0, go to PAYLOAD.
  - Accepted `wsop` word with len = 0, len > 8, or tid = `IDLE_TID`: `err_cnt`++. Go to FLUSH, or stay in IDLE if the header also carries `weop`.
  - Accepted word without `wsop`: dropped silently.
- PAYLOAD transitions:
  - Each accepted word is written at the index; index++.
  - Word at index len-1 with `weop`: go to DONE.
  - Word at index len-1 without `weop`: `err_cnt`++, drop frame, go to FLUSH.
  - `weop` before index len-1: `err_cnt`++, drop frame, go to IDLE.
  - `wsop` while in PAYLOAD: `err_cnt`++, drop current frame, process the word as a new header (IDLE rules, same cycle).
- DONE: the buffer moves to the output register when the register is empty or is freed by `fen` in the same cycle. Then go to IDLE.
- `wready` = state ≠ DONE.
- Output register:
  - Loaded: `CiData` = buffer, `CtId` = tid.
  - `fen` while occupied: clear to empty (`CtId` = `IDLE_TID`, `CiData` = 0), unless a load happens in the same cycle; load wins.
  - `fen` while empty: ignored.
- `err_cnt` saturates at 255. Never cleared except by reset.

## Timing
- Reset (async assert, sync release): FSM IDLE, index 0, buffer 0. Outputs: `CiData` = 0, `CtId` = `IDLE_TID`, `err_cnt` = 0, `busy` = 0, `wready` = 1.
- Latency: last payload word accepted in cycle N → FSM in DONE at N+1 → `CtId`/`CiData` valid at N+2 if the output register was empty.
- Back-to-back frames: `fen` in cycle M with a frame waiting in DONE → new beat visible at M+1 and `wready` high at M+1. There are no `IDLE_TID` bubbles between beats in that case.
- `fen` with nothing waiting → `CtId` = `IDLE_TID` at M+1.
- Throughput: one word per cycle while `wready` is high. A frame occupies 1+len cycles of link.
- `CiData` and `CtId` change only on load or clear. They are stable while occupied; the port samples them with a latch.
- Reset mid-frame: partial frame discarded, no `err_cnt` increment. Held beat is lost.

## Test plan
- Single frame: header tid=0x00012, len=2, then words 0xA, 0xB with `weop` on 0xB. Expect 2 cycles later `CtId`=0x00012, `CiData[127:0]`={0xB,0xA}, upper bits 0. After `fen`, `CtId`=0x3FFFFF.
- Backpressure: two len=8 frames sent back-to-back, no `fen`. Expect second frame parks in DONE and `wready` goes 0. `fen` → second beat appears the next cycle and `wready`=1.
- Bad header: len=0 and len=9 headers, each followed by 2 words with `weop`. Expect `err_cnt`=2, no beat produced, next good frame delivered correctly.
- Framing errors:
  - len=3 frame with `weop` on word 2: `err_cnt`+1.
  - len=2 frame with no `weop` on word 2, then 3 junk words ending in `weop`: `err_cnt`+1, junk flushed.
  - `wsop` inside PAYLOAD: old frame dropped, new frame delivered.
- Simultaneous `fen` and load, plus saturation: `fen` asserted in the same cycle the DONE frame loads → new beat is held and not cleared. Inject 300 bad headers → `err_cnt`=255.
- Reset mid-frame: assert `fresetn`=0 after 3 payload words. Expect all outputs at reset values, `err_cnt`=0, and the next frame delivered intact.
